// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Encoding driven on every bubble cycle unless overridden at the top.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Byte address to word address: drop the two byte-offset bits.
  localparam int unsigned WORD_SHIFT = 2;

  // BUBBLE: NOP to the core; RUN: ROM word passes straight through;
  // HOLD: core is stalled, replay the captured word.
  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_sat_counter.sv
// 32-bit event counter that sticks at all-ones and clears synchronously.
module fetch_sat_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: add one unless already saturated.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fetch_sat_counter

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end between the core PC and a 1-cycle-latency ROM.
// Handles stall (hold the presented word) and flush (inject a NOP bubble).
// Optional macro FETCH_PERF_EN builds the fetch/bubble performance counters;
// without it both counter ports read 0.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       PC,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_ok_q, pend_ok_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         unused_pc_bits;

  // The ROM address is the word index; high PC bits wrap by truncation.
  assign imem_addr      = PC[WORD_SHIFT +: ADDR_W];
  assign unused_pc_bits = ^{PC[31:ADDR_W+WORD_SHIFT], PC[WORD_SHIFT-1:0]};

  // Next state, pending-fetch tracking and hold capture.
  always_comb begin
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    pend_ok_d    = pend_ok_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    // While holding, the core keeps PC steady, so the pending fetch is frozen.
    if (state_q != HOLD) begin
      pend_pc_d = PC;
      pend_ok_d = !flush;
    end

    unique case (state_q)
      BUBBLE: state_d = flush ? BUBBLE : RUN;
      RUN: begin
        if (flush) begin
          state_d = BUBBLE;
        end else if (stall) begin
          state_d      = HOLD;
          hold_instr_d = imem_rdata;
          hold_pc_d    = pend_pc_q;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = BUBBLE;
        end else if (!stall) begin
          state_d = RUN;
        end
      end
      default: state_d = BUBBLE;
    endcase
  end

  // State and datapath registers; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BUBBLE;
      pend_pc_q    <= '0;
      pend_ok_q    <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      pend_ok_q    <= pend_ok_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Output selection: NOP bubble, live ROM word, or replayed held word.
  always_comb begin
    Instruction = NOP_INSTR;
    instr_valid = 1'b0;
    fetch_pc    = '0;
    unique case (state_q)
      RUN: begin
        instr_valid = pend_ok_q;
        Instruction = pend_ok_q ? imem_rdata : NOP_INSTR;
        fetch_pc    = pend_pc_q;
      end
      HOLD: begin
        instr_valid = 1'b1;
        Instruction = hold_instr_q;
        fetch_pc    = hold_pc_q;
      end
      default: ;
    endcase
  end

`ifdef FETCH_PERF_EN
  // A fetch is delivered when a valid word meets a non-stalled core.
  fetch_sat_counter u_fetch_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (instr_valid && !stall),
    .count (fetch_count)
  );

  fetch_sat_counter u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (state_q == BUBBLE),
    .count (bubble_count)
  );
`else
  assign fetch_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver acts as the core, predicts
// the word the core should see next cycle, and a monitor compares each cycle.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h0000_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       PC = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       Instruction;
  logic              instr_valid;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_count;
  logic [31:0]       bubble_count;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .stall        (stall),
    .flush        (flush),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .instr_valid  (instr_valid),
    .fetch_pc     (fetch_pc),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  logic [31:0] rom [DEPTH];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pc_chk;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] m_fc, m_bc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return rom[(p >> 2) % DEPTH];
  endfunction

  // One core cycle: apply inputs, then predict what the core sees next cycle.
  task automatic drive(input logic r, input logic [31:0] p, input logic s, input logic f);
    exp_t       nx;
    logic [9:0] ea;
    @(posedge clk);
    #2;
    reset = r; PC = p; stall = s; flush = f;
    #1;
    ea = 10'((p >> 2) % DEPTH);
    check("imem_addr", 32'(imem_addr), 32'(ea));

    if (r) begin
      m_fc = 0;
      m_bc = 0;
    end else begin
      if (cur.valid && !s && m_fc != 32'hFFFF_FFFF) m_fc++;
      if (!cur.valid && m_bc != 32'hFFFF_FFFF) m_bc++;
    end

    if (r || f) nx = '{valid: 1'b0, instr: NOP, pc: 32'd0, pc_chk: r, fc: 0, bc: 0};
    else if (cur.valid && s) nx = cur;
    else nx = '{valid: 1'b1, instr: rom_word(p), pc: p, pc_chk: 1'b0, fc: 0, bc: 0};
    nx.pc_chk = nx.pc_chk && r;
    nx.fc = PERF ? m_fc : 32'd0;
    nx.bc = PERF ? m_bc : 32'd0;
    sb.push_back(nx);
    cur = nx;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_valid", 32'(instr_valid), 32'(e.valid));
        if (e.valid) begin
          check("instruction", Instruction, e.instr);
          check("fetch_pc", fetch_pc, e.pc);
        end else begin
          check("bubble_nop", Instruction, NOP);
        end
        if (e.pc_chk) check("reset_fetch_pc", fetch_pc, 32'd0);
        check("fetch_count", fetch_count, e.fc);
        check("bubble_count", bubble_count, e.bc);
      end
    end
  end

  initial begin
    logic [31:0] pc_r;
    logic        r, s, f, ps, pf, pr;
    cur  = '{valid: 1'b0, instr: NOP, pc: 32'd0, pc_chk: 1'b0, fc: 0, bc: 0};
    m_fc = 0;
    m_bc = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0]  = 32'hAAAA_0001;
    rom[1]  = 32'hBBBB_0002;
    rom[2]  = 32'hCCCC_0003;
    rom[16] = 32'hDDDD_0004;

    // Reset, straight-line fetch, 3-cycle stall on B, release.
    drive(1, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h4, 0, 0);
    drive(0, 32'h8, 1, 0);
    drive(0, 32'h8, 1, 0);
    drive(0, 32'h8, 1, 0);
    drive(0, 32'h8, 0, 0);
    // Flush at PC=8, redirect to 0x40; then stall and flush together.
    drive(0, 32'h8, 0, 1);
    drive(0, 32'h40, 0, 0);
    drive(0, 32'h44, 1, 1);
    drive(0, 32'h80, 0, 0);
    // Address wrap, then reset in the middle of a hold.
    drive(0, 32'h1004, 0, 0);
    drive(0, 32'h1008, 1, 0);
    drive(0, 32'h1008, 1, 0);
    drive(1, 32'h1008, 1, 0);
    drive(0, 32'h0, 0, 0);

    // Five delivered fetches, two flushes, one reset bubble.
    drive(1, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h4, 0, 1);
    drive(0, 32'h8, 0, 0);
    drive(0, 32'hC, 0, 0);
    drive(0, 32'h10, 0, 1);
    drive(0, 32'h14, 0, 0);
    drive(0, 32'h18, 0, 0);
    drive(0, 32'h1C, 0, 0);
    drive(0, 32'h20, 0, 0);
    check("perf_fetch_total", fetch_count, PERF ? 32'd5 : 32'd0);
    check("perf_bubble_total", bubble_count, PERF ? 32'd3 : 32'd0);

    // Randomized core behaviour; PC is held while the core is stalled.
    pc_r = 32'h24;
    ps = 0; pf = 0; pr = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      if (ps && !pf && !pr) pc_r = pc_r;
      else if (pf || $urandom_range(0, 15) == 0) pc_r = $urandom;
      else pc_r = pc_r + 32'd4;
      drive(r, pc_r, s, f);
      ps = s; pf = f; pr = r;
    end

    repeat (2) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
